lock_code_checker: RTL
======================

// Module: lock_code_checker
// PURPOSE
//   Downstream consumer of the lock digit counter (Lock_Counter). Each time the user confirms the
//   counter value (numCounter), that value enters here as one code digit. The block checks the
//   NUM_DIGITS-long entry against a stored combination and drives unlock/alarm. It also pulses
//   cnt_clr so the counter restarts for the next digit.
// PARAMETERS
//   WIDTH          5        digit width; matches numCounter
//   NUM_DIGITS     4        digits per combination, >=2
//   CODE           20'hC8CF2 packed combination; digit k = CODE[k*WIDTH +: WIDTH] (default 18,7,3,25)
//   MAX_FAILS      3        consecutive wrong entries before lockout, >=1
//   OPEN_CYCLES    8        cycles unlocked stays high before auto-relock, >=1
//   LOCKOUT_CYCLES 16       cycles alarm stays high, >=1
// PORTS
//   CLK          in   1                         rising-edge clock
//   RST          in   1                         synchronous, active-high reset
//   digit        in   WIDTH                     current counter value (numCounter)
//   digit_valid  in   1                         1-cycle strobe: accept digit
//   abort        in   1                         discard partial entry
//   relock       in   1                         force relock while OPEN
//   unlocked     out  1                         high in OPEN
//   alarm        out  1                         high in LOCKOUT
//   digit_idx    out  $clog2(NUM_DIGITS)        index of next expected digit
//   fail_cnt     out  $clog2(MAX_FAILS+1)       consecutive failed entries
//   cnt_clr      out  1                         1-cycle pulse to clear the upstream counter
// BEHAVIOUR
//   - Reset: state=ENTRY, digit_idx=0, mismatch=0, fail_cnt=0, unlocked=0, alarm=0, cnt_clr=0.
//     Reset wins over every other input, in any state, including mid-entry, OPEN and LOCKOUT.
//   - FSM states: ENTRY, OPEN, LOCKOUT. All outputs are registered.
//   - ENTRY, digit_valid=1 and abort=0:
//       - mismatch |= (digit != CODE[digit_idx]). The mismatch flag is sticky and never reveals
//         which digit was wrong.
//       - cnt_clr=1 on the next cycle.
//       - If digit_idx < NUM_DIGITS-1: digit_idx++.
//       - On the last digit: digit_idx=0 and mismatch=0.
//         - Match: go to OPEN and set fail_cnt=0.
//         - Else if fail_cnt+1 == MAX_FAILS: go to LOCKOUT.
//         - Else: fail_cnt++ and stay in ENTRY.
//       - unlocked or alarm rises 1 cycle after the last strobe.
//   - ENTRY, abort=1: digit_idx=0, mismatch=0, cnt_clr pulses, fail_cnt is unchanged. Abort wins
//     over a simultaneous digit_valid.
//   - OPEN: a timer counts OPEN_CYCLES. unlocked is high for exactly OPEN_CYCLES cycles, then the
//     FSM returns to ENTRY. relock=1 returns to ENTRY next cycle. digit_valid and abort are ignored.
//   - LOCKOUT: alarm is high for exactly LOCKOUT_CYCLES cycles. fail_cnt holds MAX_FAILS during
//     LOCKOUT. On exit: ENTRY, fail_cnt=0, cnt_clr pulses. digit_valid, abort and relock are
//     ignored.
//   - Digit compare is an unsigned WIDTH-bit equality; there is no wrap or arithmetic on digits.
//     The timer width is $clog2(max(OPEN_CYCLES,LOCKOUT_CYCLES)+1), and the timer is loaded on
//     state entry.
//   - digit_valid held high for N cycles counts as N strobes. The upstream logic is responsible
//     for generating single-cycle pulses.
// STRUCTURE
//   - Shared package lock_pkg: state encoding localparams (ST_ENTRY, ST_OPEN, ST_LOCKOUT),
//     LOCK_WIDTH=5, and the default code constant. The same package is used by Lock_Counter.
//   - One sub-module: lock_timer. It is a loadable down-counter with a done flag, used for both
//     OPEN and LOCKOUT.
// TESTING
//   1. Strobe 18,7,3,25 -> unlocked=1 for 8 cycles starting 1 cycle after the 4th strobe;
//      cnt_clr pulses 4 times; fail_cnt=0.
//   2. Strobe 18,7,4,25 -> unlocked stays 0, fail_cnt=1, digit_idx=0. Then a correct entry
//      -> unlocked=1 and fail_cnt=0.
//   3. Three wrong entries -> alarm=1 for 16 cycles. Strobes during that time are ignored.
//      Afterwards fail_cnt=0, and a correct entry unlocks.
//   4. Strobe 18,7, then abort asserted in the same cycle as digit 3 -> digit_idx=0,
//      fail_cnt unchanged, and no unlock.
//   5. Unlock, then relock at cycle 3 of OPEN -> unlocked=0 next cycle. Unlock again, then RST
//      at cycle 2 -> all outputs return to reset values.
//   6. RST asserted during LOCKOUT -> alarm=0 and fail_cnt=0 next cycle.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared lock definitions: FSM state encoding, digit width and the default combination.
// Used by both the digit counter and the code checker.
package lock_pkg;

  localparam logic [1:0] ST_ENTRY   = 2'd0;
  localparam logic [1:0] ST_OPEN    = 2'd1;
  localparam logic [1:0] ST_LOCKOUT = 2'd2;

  localparam int LOCK_WIDTH = 5;

  // Digits 18,7,3,25 packed LSB-first, one per LOCK_WIDTH-bit slot.
  localparam logic [19:0] LOCK_CODE = 20'hC8CF2;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter with a done flag; load has priority and the count stops at zero.
// done is high from the cycle after load_val==0 is loaded, or once the count reaches zero.
module lock_timer #(
  parameter int TW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          done
);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - TW'(1);
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/lock_code_checker.sv
// Collects confirmed digits, compares the entry against CODE, drives unlocked/alarm and cnt_clr.
// All outputs registered: the verdict appears one cycle after the last digit strobe.
module lock_code_checker
  import lock_pkg::*;
#(
  parameter int                          WIDTH          = LOCK_WIDTH,
  parameter int                          NUM_DIGITS     = 4,
  parameter logic [WIDTH*NUM_DIGITS-1:0] CODE           = LOCK_CODE,
  parameter int                          MAX_FAILS      = 3,
  parameter int                          OPEN_CYCLES    = 8,
  parameter int                          LOCKOUT_CYCLES = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [WIDTH-1:0]              digit,
  input  logic                          digit_valid,
  input  logic                          abort,
  input  logic                          relock,
  output logic                          unlocked,
  output logic                          alarm,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt,
  output logic                          cnt_clr
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int TW = $clog2(max2(OPEN_CYCLES, LOCKOUT_CYCLES) + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    idx_d;
  logic             mm_q, mm_d;
  logic [FW-1:0]    fail_d;
  logic             clr_d, unl_d, alm_d;
  logic             tmr_load, tmr_done;
  logic [TW-1:0]    tmr_val;
  logic [WIDTH-1:0] exp_digit;
  logic             miss;

  assign exp_digit = CODE[int'(digit_idx)*WIDTH +: WIDTH];
  // Sticky: any wrong digit poisons the whole entry without revealing which one.
  assign miss      = mm_q | (digit != exp_digit);

  lock_timer #(.TW(TW)) u_timer (
    .clk      (CLK),
    .rst      (RST),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_ENTRY;
      digit_idx <= '0;
      mm_q      <= 1'b0;
      fail_cnt  <= '0;
      cnt_clr   <= 1'b0;
      unlocked  <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      state_q   <= state_d;
      digit_idx <= idx_d;
      mm_q      <= mm_d;
      fail_cnt  <= fail_d;
      cnt_clr   <= clr_d;
      unlocked  <= unl_d;
      alarm     <= alm_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = digit_idx;
    mm_d     = mm_q;
    fail_d   = fail_cnt;
    clr_d    = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_ENTRY: begin
        if (abort) begin
          idx_d = '0;
          mm_d  = 1'b0;
          clr_d = 1'b1;
        end else if (digit_valid) begin
          clr_d = 1'b1;
          if (digit_idx == LAST_IDX) begin
            idx_d = '0;
            mm_d  = 1'b0;
            if (!miss) begin
              state_d  = ST_OPEN;
              fail_d   = '0;
              tmr_load = 1'b1;
              tmr_val  = TW'(OPEN_CYCLES - 1);
            end else if (fail_cnt + FW'(1) == FW'(MAX_FAILS)) begin
              state_d  = ST_LOCKOUT;
              fail_d   = FW'(MAX_FAILS);
              tmr_load = 1'b1;
              tmr_val  = TW'(LOCKOUT_CYCLES - 1);
            end else begin
              fail_d = fail_cnt + FW'(1);
            end
          end else begin
            idx_d = digit_idx + IW'(1);
            mm_d  = miss;
          end
        end
      end
      ST_OPEN: begin
        if (relock || tmr_done) state_d = ST_ENTRY;
      end
      ST_LOCKOUT: begin
        if (tmr_done) begin
          state_d = ST_ENTRY;
          fail_d  = '0;
          clr_d   = 1'b1;
        end
      end
      default: state_d = ST_ENTRY;
    endcase
  end

  always_comb begin
    unl_d = (state_d == ST_OPEN);
    alm_d = (state_d == ST_LOCKOUT);
  end

endmodule
